// File: rtl/fmap_streamer.sv
// Streams one FIG_WIDTH x FIG_HEIGHT feature map, in row-major order, out of a synchronous-read SRAM.
// Reads are credit-limited so that the 2-entry output FIFO can never overflow under backpressure.
module fmap_streamer #(
   parameter int WORDWIDTH  = 32,
   parameter int FIG_WIDTH  = 28,
   parameter int FIG_HEIGHT = 28,
   parameter int ADDRLEN    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDRLEN-1:0]   base_addr,
   output logic                 mem_en,
   output logic [ADDRLEN-1:0]   mem_addr,
   input  logic [WORDWIDTH-1:0] mem_rdata,
   output logic [WORDWIDTH-1:0] dout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam int N  = FIG_WIDTH * FIG_HEIGHT;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state, state_nxt;
   logic [ADDRLEN-1:0]   base_q, addr_q, issue_addr;
   logic [CW-1:0]        issue_idx, xfer_idx;
   logic                 inflight;
   logic [WORDWIDTH-1:0] fifo_mem [2];
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           fifo_count;
   logic                 push, pop;

   assign out_valid  = (fifo_count != 2'd0);
   assign dout       = fifo_mem[rd_ptr];
   assign pop        = out_valid & out_ready;
   assign push       = inflight;
   assign out_last   = out_valid && (xfer_idx == CW'(N - 1));
   assign issue_addr = base_q + ADDRLEN'(issue_idx);
   assign mem_addr   = mem_en ? issue_addr : addr_q;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            // Credits: words in the FIFO plus the read in flight, less this cycle's pop, must stay below 2.
            mem_en = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
            if (mem_en && (issue_idx == CW'(N - 1))) state_nxt = DRAIN;
         end
         DRAIN: if (pop && out_last) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         base_q     <= '0;
         addr_q     <= '0;
         issue_idx  <= '0;
         xfer_idx   <= '0;
         inflight   <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
         // NOTE: the two FIFO words are reset because dout exposes the head directly and must read 0.
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= mem_en;
         if (state == IDLE && start) begin
            base_q    <= base_addr;
            issue_idx <= '0;
            xfer_idx  <= '0;
         end
         if (mem_en) begin
            issue_idx <= issue_idx + 1'b1;
            addr_q    <= issue_addr;
         end
         if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            xfer_idx <= xfer_idx + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: doc/fmap_streamer.md
Name: fmap_streamer

Overview:
- Upstream feeder for the line buffer. On a start pulse it reads one FIG_WIDTH x FIG_HEIGHT feature map, row-major, from a synchronous-read on-chip SRAM.
- It emits the map as a one-word-per-beat valid/ready stream whose dout/out_valid drive the line buffer's din/in_valid.
- A 2-entry credit-controlled output FIFO absorbs the 1-cycle SRAM read latency and downstream stalls, so no pixel is lost or duplicated.

Parameters:
- WORDWIDTH, 32, pixel/word width in bits.
- FIG_WIDTH, 28, pixels per row.
- FIG_HEIGHT, 28, rows per frame.
- ADDRLEN, 16, SRAM address width in bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- base_addr  in  ADDRLEN  SRAM address of pixel (0,0); sampled with start.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  ADDRLEN  SRAM read address.
- mem_rdata  in  WORDWIDTH  SRAM read data; valid the cycle after mem_en.
- dout  out  WORDWIDTH  pixel to line buffer.
- out_valid  out  1  dout valid.
- out_ready  in  1  consumer accepts; tie to 1 when driving the line buffer.
- out_last  out  1  qualifies the final pixel of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final pixel transfers.

Behaviour:
- Reset (rst=1 at an edge) takes effect in the same cycle regardless of state:
  - mem_en, mem_addr, dout, out_valid, out_last, busy and done all go to 0.
  - FSM goes to IDLE; issue/transfer counters clear; FIFO empties.
  - Any in-flight read is discarded, and its returning mem_rdata is not written.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start=1; latch base_addr.
  - RUN -> DRAIN at the edge where the read for index N-1 issues, with N = FIG_WIDTH*FIG_HEIGHT.
  - DRAIN -> DONE at the edge where the pixel with index N-1 transfers.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE is ignored (no restart, no latch).
- busy = (state != IDLE). done = (state == DONE).
- Read issue: mem_en=1 in RUN only when fifo_count + inflight - pop < 2.
  - pop = out_valid & out_ready this cycle; inflight = mem_en registered one cycle.
  - This guarantees the FIFO never overflows.
- mem_addr = base_addr + issue_idx, modulo 2^ADDRLEN (wraps silently).
- issue_idx increments per mem_en. mem_addr holds its last value when mem_en=0.
- Capture: a registered inflight bit writes mem_rdata into the FIFO at the end of the cycle it is valid.
- Simultaneous FIFO push and pop is legal, and count is unchanged.
- Output handshake:
  - out_valid = FIFO non-empty; dout = FIFO head.
  - Transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, dout and out_last must stay stable.
- out_last=1 exactly when the head is transfer index N-1, tracked by a transfer counter.
- Latency with start sampled at edge T and out_ready=1:
  - mem_en=1 during cycle T+1.
  - out_valid=1 from cycle T+3.
  - Sustained 1 pixel/cycle thereafter.
  - Final pixel presented in cycle T+2+N; done=1 in cycle T+3+N.
- Backpressure: after out_ready falls, at most 2 words are buffered. mem_en stays low until a slot frees.
- No data depends on out_ready when out_valid=0.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random start and out_ready -> all outputs 0, mem_en never 1.
- Full frame, defaults, out_ready=1, SRAM model with rdata=addr, base_addr=0x0100, start at edge T:
  - dout runs 0x0100..0x040F contiguously.
  - out_last only on 0x040F, in cycle T+786.
  - done=1 in cycle T+787 only; busy=0 from T+788.
- Alternating backpressure, out_ready toggling 1,0,1,0: all 784 words arrive in order, no duplicates. Checker asserts fifo_count + inflight <= 2 every cycle.
- Stall: out_ready=0 for 10 cycles starting at pixel 200 -> dout frozen at 0x01C8, mem_en low after at most 2 outstanding reads. Resumes with 0x01C8 accepted first.
- Control edges:
  - start pulsed mid-frame is ignored; the frame completes unchanged.
  - rst at pixel 100 -> all outputs 0 next cycle.
  - A new start then restarts from index 0 with the new base_addr.
- Address wrap: ADDRLEN=16, base_addr=0xFFF0 -> mem_addr sequence 0xFFF0..0xFFFF, 0x0000, 0x0001, ... with dout following.
